// File: rtl/uart_xcvr_fifo.sv
// UART transceiver: 16x oversampling tick, RX with sync/parity/framing check, TX, one FIFO per side.
// Define UART_BREAK_DET_EN to enable break detection (rx_break and the RX BREAK state).

module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_sys,
   input  logic             rst_clk_sys,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // Callers only assert wr_en when not full and rd_en when not empty.
   always_ff @(posedge clk_sys or posedge rst_clk_sys) begin
      if (rst_clk_sys) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
endmodule

// State table
//   RX_IDLE   | waiting for a low line on a tick
//   RX_START  | counting to the start-bit centre, glitch check
//   RX_DATA   | sampling data bits LSB first
//   RX_PARITY | sampling the parity bit
//   RX_STOP   | sampling the stop bit and pushing the character
//   RX_BREAK  | (break build only) waiting for 16 high ticks
//   TX_IDLE   | waiting for a character in the TX FIFO
//   TX_START  | driving the start bit
//   TX_DATA   | driving data bits LSB first
//   TX_PARITY | driving the parity bit
//   TX_STOP   | driving STOP_BITS stop bits
module uart_xcvr_fifo #(
   parameter int CLOCK_RATE    = 100_000_000,
   parameter int BAUD_RATE     = 9600,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int TX_FIFO_DEPTH = 16,
   parameter int RX_FIFO_DEPTH = 16
) (
   input  logic                 clk_sys,
   input  logic                 rst_clk_sys,
   input  logic                 rxd_i,
   output logic                 txd_o,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_wr_en,
   output logic                 tx_full,
   output logic                 tx_idle,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_rd_en,
   output logic                 rx_frm_err,
   output logic                 rx_par_err,
   output logic                 rx_overrun,
   input  logic                 rx_err_clr,
   output logic                 rx_break
);
   localparam int DIV_RAW = (CLOCK_RATE + 8 * BAUD_RATE) / (16 * BAUD_RATE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [2:0] BIT_LAST     = 3'(DATA_BITS - 1);
   localparam logic [4:0] TX_STOP_LAST = 5'(STOP_BITS * 16 - 1);

   // ---------------- baud tick ----------------
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   always_ff @(posedge clk_sys or posedge rst_clk_sys) begin
      if (rst_clk_sys)          div_cnt <= '0;
      else if (div_cnt == '0)   div_cnt <= DIV_W'(DIV - 1);
      else                      div_cnt <= div_cnt - DIV_W'(1);
   end
   assign tick = (div_cnt == '0);

   // ---------------- receiver ----------------
   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
`ifdef UART_BREAK_DET_EN
      , RX_BREAK
`endif
   } rx_state_t;

   rx_state_t            rx_state, rx_state_d;
   logic [1:0]           rx_sync;
   logic                 rx_line;
   logic [3:0]           rx_cnt, rx_cnt_d;
   logic [2:0]           rx_bit, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
   logic                 rx_pbit, rx_pbit_d;
   logic                 rx_push, rx_frm_new, rx_par_new;
   logic                 rx_wr, rx_pop, rx_full, rx_empty;
   logic [DATA_BITS+1:0] rx_head;
   logic                 ovr_set;
   logic                 rx_overrun_q;

   assign rx_line = rx_sync[1];

   always_comb begin
      case (PARITY)
         1:       rx_par_new = ~((^rx_shift) ^ rx_pbit);
         2:       rx_par_new = (^rx_shift) ^ rx_pbit;
         default: rx_par_new = 1'b0;
      endcase
   end

`ifdef UART_BREAK_DET_EN
   logic brk_set;
   logic rx_break_q;
`endif

   always_ff @(posedge clk_sys or posedge rst_clk_sys) begin
      if (rst_clk_sys) begin
         rx_state <= RX_IDLE;
         rx_sync  <= 2'b11;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_pbit  <= 1'b0;
      end else begin
         rx_state <= rx_state_d;
         rx_sync  <= {rx_sync[0], rxd_i};
         rx_cnt   <= rx_cnt_d;
         rx_bit   <= rx_bit_d;
         rx_shift <= rx_shift_d;
         rx_pbit  <= rx_pbit_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state;
      rx_cnt_d   = rx_cnt;
      rx_bit_d   = rx_bit;
      rx_shift_d = rx_shift;
      rx_pbit_d  = rx_pbit;
      rx_push    = 1'b0;
      rx_frm_new = 1'b0;
`ifdef UART_BREAK_DET_EN
      brk_set    = 1'b0;
`endif
      case (rx_state)
         RX_IDLE: begin
            if (tick && !rx_line) begin
               rx_state_d = RX_START;
               rx_cnt_d   = 4'd7;
            end
         end
         RX_START: begin
            if (tick) begin
               if (rx_cnt != '0) rx_cnt_d = rx_cnt - 4'd1;
               else if (rx_line) rx_state_d = RX_IDLE;
               else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = 4'd15;
                  rx_bit_d   = '0;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               if (rx_cnt != '0) rx_cnt_d = rx_cnt - 4'd1;
               else begin
                  rx_shift_d = {rx_line, rx_shift[DATA_BITS-1:1]};
                  rx_cnt_d   = 4'd15;
                  rx_bit_d   = rx_bit + 3'd1;
                  if (rx_bit == BIT_LAST)
                     rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
               end
            end
         end
         RX_PARITY: begin
            if (tick) begin
               if (rx_cnt != '0) rx_cnt_d = rx_cnt - 4'd1;
               else begin
                  rx_pbit_d  = rx_line;
                  rx_cnt_d   = 4'd15;
                  rx_state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (rx_cnt != '0) rx_cnt_d = rx_cnt - 4'd1;
               else begin
                  rx_push    = 1'b1;
                  rx_frm_new = !rx_line;
                  rx_state_d = RX_IDLE;
`ifdef UART_BREAK_DET_EN
                  // rx_pbit stays 0 in no-parity builds, so it only matters when a parity bit exists.
                  if (!rx_line && (rx_shift == '0) && !rx_pbit) begin
                     brk_set    = 1'b1;
                     rx_state_d = RX_BREAK;
                     rx_cnt_d   = 4'd15;
                  end
`endif
               end
            end
         end
`ifdef UART_BREAK_DET_EN
         RX_BREAK: begin
            if (tick) begin
               if (!rx_line)           rx_cnt_d   = 4'd15;
               else if (rx_cnt == '0)  rx_state_d = RX_IDLE;
               else                    rx_cnt_d   = rx_cnt - 4'd1;
            end
         end
`endif
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign rx_wr   = rx_push && !rx_full;
   assign ovr_set = rx_push && rx_full;
   assign rx_pop  = rx_rd_en && !rx_empty;

   uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
      .clk_sys     (clk_sys),
      .rst_clk_sys (rst_clk_sys),
      .wr_en       (rx_wr),
      .wr_data     ({rx_par_new, rx_frm_new, rx_shift}),
      .rd_en       (rx_pop),
      .rd_data     (rx_head),
      .empty       (rx_empty),
      .full        (rx_full)
   );

   // Set wins over clear when both happen in one cycle.
   always_ff @(posedge clk_sys or posedge rst_clk_sys) begin
      if (rst_clk_sys)     rx_overrun_q <= 1'b0;
      else if (ovr_set)    rx_overrun_q <= 1'b1;
      else if (rx_err_clr) rx_overrun_q <= 1'b0;
   end

`ifdef UART_BREAK_DET_EN
   always_ff @(posedge clk_sys or posedge rst_clk_sys) begin
      if (rst_clk_sys)     rx_break_q <= 1'b0;
      else if (brk_set)    rx_break_q <= 1'b1;
      else if (rx_err_clr) rx_break_q <= 1'b0;
   end
   assign rx_break = rx_break_q;
`else
   assign rx_break = 1'b0;
`endif

   // FIFO memory is not reset, so the head is masked while empty.
   assign rx_valid   = !rx_empty;
   assign rx_data    = rx_valid ? rx_head[DATA_BITS-1:0] : '0;
   assign rx_frm_err = rx_valid & rx_head[DATA_BITS];
   assign rx_par_err = rx_valid & rx_head[DATA_BITS+1];
   assign rx_overrun = rx_overrun_q;

   // ---------------- transmitter ----------------
   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   tx_state_t            tx_state, tx_state_d;
   logic [4:0]           tx_cnt, tx_cnt_d;
   logic [2:0]           tx_bit, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
   logic                 tx_pbit, tx_pbit_d;
   logic                 tx_txd, tx_txd_d;
   logic                 tx_wr, tx_pop, tx_empty;
   logic [DATA_BITS-1:0] tx_head;
   logic                 head_par;

   assign head_par = (PARITY == 1) ? ~(^tx_head) : (^tx_head);

   always_ff @(posedge clk_sys or posedge rst_clk_sys) begin
      if (rst_clk_sys) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_pbit  <= 1'b0;
         tx_txd   <= 1'b1;
      end else begin
         tx_state <= tx_state_d;
         tx_cnt   <= tx_cnt_d;
         tx_bit   <= tx_bit_d;
         tx_shift <= tx_shift_d;
         tx_pbit  <= tx_pbit_d;
         tx_txd   <= tx_txd_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state;
      tx_cnt_d   = tx_cnt;
      tx_bit_d   = tx_bit;
      tx_shift_d = tx_shift;
      tx_pbit_d  = tx_pbit;
      tx_txd_d   = tx_txd;
      tx_pop     = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (tick && !tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_pbit_d  = head_par;
               tx_txd_d   = 1'b0;
               tx_cnt_d   = 5'd15;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tick) begin
               if (tx_cnt != '0) tx_cnt_d = tx_cnt - 5'd1;
               else begin
                  tx_state_d = TX_DATA;
                  tx_txd_d   = tx_shift[0];
                  tx_cnt_d   = 5'd15;
                  tx_bit_d   = '0;
               end
            end
         end
         TX_DATA: begin
            if (tick) begin
               if (tx_cnt != '0) tx_cnt_d = tx_cnt - 5'd1;
               else if (tx_bit == BIT_LAST) begin
                  if (PARITY != 0) begin
                     tx_state_d = TX_PARITY;
                     tx_txd_d   = tx_pbit;
                     tx_cnt_d   = 5'd15;
                  end else begin
                     tx_state_d = TX_STOP;
                     tx_txd_d   = 1'b1;
                     tx_cnt_d   = TX_STOP_LAST;
                  end
               end else begin
                  tx_bit_d   = tx_bit + 3'd1;
                  tx_shift_d = tx_shift >> 1;
                  tx_txd_d   = tx_shift[1];
                  tx_cnt_d   = 5'd15;
               end
            end
         end
         TX_PARITY: begin
            if (tick) begin
               if (tx_cnt != '0) tx_cnt_d = tx_cnt - 5'd1;
               else begin
                  tx_state_d = TX_STOP;
                  tx_txd_d   = 1'b1;
                  tx_cnt_d   = TX_STOP_LAST;
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (tx_cnt != '0) tx_cnt_d = tx_cnt - 5'd1;
               else if (!tx_empty) begin
                  // Next character starts straight after the stop bits.
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_head;
                  tx_pbit_d  = head_par;
                  tx_txd_d   = 1'b0;
                  tx_cnt_d   = 5'd15;
                  tx_state_d = TX_START;
               end else tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign tx_wr = tx_wr_en && !tx_full;

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
      .clk_sys     (clk_sys),
      .rst_clk_sys (rst_clk_sys),
      .wr_en       (tx_wr),
      .wr_data     (tx_data),
      .rd_en       (tx_pop),
      .rd_data     (tx_head),
      .empty       (tx_empty),
      .full        (tx_full)
   );

   assign txd_o   = tx_txd;
   assign tx_idle = tx_empty && (tx_state == TX_IDLE);
endmodule

// File: tb/tb_uart_xcvr_fifo.sv
// Directed bench for uart_xcvr_fifo: three instances (8N1, 8E2, 8O1) at 16 clocks per bit.
// Expected serial bits and RX FIFO entries flow through scoreboard queues.
module tb_uart_xcvr_fifo;
   localparam int CR = 1_600_000;
   localparam int BR = 100_000;

   logic       clk_sys = 1'b0;
   logic       rst     = 1'b1;
   logic [1:0] sel     = 2'd0;
   logic       rxd     = 1'b1;
   logic       tx_wr   = 1'b0;
   logic       rd_en   = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] tx_data = 8'h00;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic       tx_q [$];
   logic [9:0] rx_q [$];

   wire [2:0] txd_v, tx_full_v, tx_idle_v, rx_valid_v, frm_v, par_v, ovr_v, brk_v;
   wire [7:0] rx_data_v [3];

   always #5 clk_sys = ~clk_sys;

   uart_xcvr_fifo #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .TX_FIFO_DEPTH(4), .RX_FIFO_DEPTH(4)) u_n (
      .clk_sys(clk_sys), .rst_clk_sys(rst), .rxd_i(sel == 2'd0 ? rxd : 1'b1), .txd_o(txd_v[0]),
      .tx_data(tx_data), .tx_wr_en(sel == 2'd0 && tx_wr), .tx_full(tx_full_v[0]), .tx_idle(tx_idle_v[0]),
      .rx_data(rx_data_v[0]), .rx_valid(rx_valid_v[0]), .rx_rd_en(sel == 2'd0 && rd_en),
      .rx_frm_err(frm_v[0]), .rx_par_err(par_v[0]), .rx_overrun(ovr_v[0]),
      .rx_err_clr(sel == 2'd0 && err_clr), .rx_break(brk_v[0]));

   uart_xcvr_fifo #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                    .TX_FIFO_DEPTH(16), .RX_FIFO_DEPTH(16)) u_e (
      .clk_sys(clk_sys), .rst_clk_sys(rst), .rxd_i(sel == 2'd1 ? rxd : 1'b1), .txd_o(txd_v[1]),
      .tx_data(tx_data), .tx_wr_en(sel == 2'd1 && tx_wr), .tx_full(tx_full_v[1]), .tx_idle(tx_idle_v[1]),
      .rx_data(rx_data_v[1]), .rx_valid(rx_valid_v[1]), .rx_rd_en(sel == 2'd1 && rd_en),
      .rx_frm_err(frm_v[1]), .rx_par_err(par_v[1]), .rx_overrun(ovr_v[1]),
      .rx_err_clr(sel == 2'd1 && err_clr), .rx_break(brk_v[1]));

   uart_xcvr_fifo #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                    .TX_FIFO_DEPTH(16), .RX_FIFO_DEPTH(16)) u_o (
      .clk_sys(clk_sys), .rst_clk_sys(rst), .rxd_i(sel == 2'd2 ? rxd : 1'b1), .txd_o(txd_v[2]),
      .tx_data(tx_data), .tx_wr_en(sel == 2'd2 && tx_wr), .tx_full(tx_full_v[2]), .tx_idle(tx_idle_v[2]),
      .rx_data(rx_data_v[2]), .rx_valid(rx_valid_v[2]), .rx_rd_en(sel == 2'd2 && rd_en),
      .rx_frm_err(frm_v[2]), .rx_par_err(par_v[2]), .rx_overrun(ovr_v[2]),
      .rx_err_clr(sel == 2'd2 && err_clr), .rx_break(brk_v[2]));

   wire       txd_m      = txd_v[sel];
   wire       tx_full_m  = tx_full_v[sel];
   wire       tx_idle_m  = tx_idle_v[sel];
   wire       rx_valid_m = rx_valid_v[sel];
   wire [7:0] rx_data_m  = rx_data_v[sel];
   wire       frm_m      = frm_v[sel];
   wire       par_m      = par_v[sel];
   wire       ovr_m      = ovr_v[sel];
   wire       brk_m      = brk_v[sel];

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Queue one character and check every bit of the frame at its centre, then the frame length.
   task automatic tx_frame(input logic [7:0] d, input int par_mode, input int stops, input string tag);
      bit   seen = 1'b0;
      int   n = 0;
      logic e;
      tx_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) tx_q.push_back(d[i]);
      if (par_mode == 1) tx_q.push_back(~(^d));
      else if (par_mode == 2) tx_q.push_back(^d);
      for (int i = 0; i < stops; i++) tx_q.push_back(1'b1);
      tx_data = d;
      tx_wr   = 1'b1;
      clk_n(1);
      tx_wr   = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (txd_m == 1'b0) seen = 1'b1;
         else clk_n(1);
      end
      chk($sformatf("%s_start_seen", tag), seen, 1);
      if (seen) begin
         clk_n(8);
         while (tx_q.size() > 0) begin
            e = tx_q.pop_front();
            chk($sformatf("%s_bit%0d", tag, n), txd_m, e);
            n++;
            if (tx_q.size() > 0) clk_n(16);
         end
         clk_n(7);
         chk($sformatf("%s_busy_at_end", tag), tx_idle_m, 0);
         clk_n(1);
         chk($sformatf("%s_idle_after", tag), tx_idle_m, 1);
      end else tx_q.delete();
   endtask

   task automatic rx_send(input logic [7:0] d, input int par_mode, input logic par_flip, input logic stop_val);
      logic p;
      rx_q.push_back({(par_mode != 0) && par_flip, !stop_val, d});
      rxd = 1'b0;
      clk_n(16);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         clk_n(16);
      end
      if (par_mode != 0) begin
         p   = (par_mode == 1) ? ~(^d) : (^d);
         rxd = p ^ par_flip;
         clk_n(16);
      end
      rxd = stop_val;
      clk_n(16);
      rxd = 1'b1;
   endtask

   task automatic rx_read(input string tag);
      logic [9:0] e;
      int         w = 0;
      while (!rx_valid_m && w < 40) begin
         clk_n(1);
         w++;
      end
      chk($sformatf("%s_valid", tag), rx_valid_m, 1);
      e = rx_q.pop_front();
      chk($sformatf("%s_data", tag), rx_data_m, e[7:0]);
      chk($sformatf("%s_frm", tag), frm_m, e[8]);
      chk($sformatf("%s_par", tag), par_m, e[9]);
      rd_en = 1'b1;
      clk_n(1);
      rd_en = 1'b0;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      clk_n(3);
      chk("rst_txd", txd_m, 1);
      chk("rst_tx_full", tx_full_m, 0);
      chk("rst_tx_idle", tx_idle_m, 1);
      chk("rst_rx_valid", rx_valid_m, 0);
      chk("rst_rx_data", rx_data_m, 0);
      chk("rst_frm", frm_m, 0);
      chk("rst_par", par_m, 0);
      chk("rst_ovr", ovr_m, 0);
      chk("rst_brk", brk_m, 0);
      rst = 1'b0;
      clk_n(4);

      // transmit
      sel = 2'd0; tx_frame(8'hA5, 0, 1, "tx_8n1");
      sel = 2'd1; tx_frame(8'hA5, 2, 2, "tx_8e2");
      sel = 2'd2; tx_frame(8'hA5, 1, 1, "tx_8o1");

      // TX FIFO fills (one entry already popped), sixth push dropped, five frames back-to-back
      sel   = 2'd0;
      tx_wr = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tx_data = 8'(i);
         clk_n(1);
         if (i == 5) chk("tx_full_after_5", tx_full_m, 1);
      end
      tx_wr = 1'b0;
      clk_n(795);
      chk("tx_burst_busy", tx_idle_m, 0);
      clk_n(1);
      chk("tx_burst_idle", tx_idle_m, 1);

      // receive loop
      sel = 2'd0;
      rx_send(8'h3C, 0, 1'b0, 1'b1);
      rx_send(8'hFF, 0, 1'b0, 1'b1);
      rx_send(8'h00, 0, 1'b0, 1'b1);
      rx_read("rx_3c");
      rx_read("rx_ff");
      rx_read("rx_00");
      chk("rx_loop_empty", rx_valid_m, 0);

      // framing error, then a short glitch
      rx_send(8'h55, 0, 1'b0, 1'b0);
      rx_read("rx_frm55");
      clk_n(20);
      chk("rx_frm_no_extra", rx_valid_m, 0);
      rxd = 1'b0;
      clk_n(6);
      rxd = 1'b1;
      clk_n(40);
      chk("rx_glitch_ignored", rx_valid_m, 0);

      // parity checks
      sel = 2'd2;
      rx_send(8'h5A, 1, 1'b1, 1'b1);
      rx_read("rx_odd_bad");
      rx_send(8'hC3, 1, 1'b0, 1'b1);
      rx_read("rx_odd_good");
      sel = 2'd1;
      rx_send(8'h5B, 2, 1'b0, 1'b1);
      rx_read("rx_even_good");
      rx_send(8'h5B, 2, 1'b1, 1'b1);
      rx_read("rx_even_bad");

      // overrun with a 4-deep RX FIFO
      sel = 2'd0;
      rx_send(8'h11, 0, 1'b0, 1'b1);
      rx_send(8'h22, 0, 1'b0, 1'b1);
      rx_send(8'h33, 0, 1'b0, 1'b1);
      rx_send(8'h44, 0, 1'b0, 1'b1);
      chk("ovr_not_yet", ovr_m, 0);
      rx_send(8'h55, 0, 1'b0, 1'b1);
      void'(rx_q.pop_back());
      clk_n(4);
      chk("ovr_set", ovr_m, 1);
      rx_read("ovr_11");
      rx_read("ovr_22");
      rx_read("ovr_33");
      rx_read("ovr_44");
      chk("ovr_drained", rx_valid_m, 0);
      chk("ovr_sticky", ovr_m, 1);
      err_clr = 1'b1;
      clk_n(1);
      err_clr = 1'b0;
      chk("ovr_cleared", ovr_m, 0);

`ifdef UART_BREAK_DET_EN
      rx_q.push_back({1'b0, 1'b1, 8'h00});
      rxd = 1'b0;
      clk_n(320);
      rxd = 1'b1;
      clk_n(40);
      chk("brk_set", brk_m, 1);
      rx_read("brk_entry");
      clk_n(1);
      chk("brk_single_entry", rx_valid_m, 0);
      err_clr = 1'b1;
      clk_n(1);
      err_clr = 1'b0;
      chk("brk_cleared", brk_m, 0);
`else
      rx_send(8'h00, 0, 1'b0, 1'b0);
      rx_read("nobrk_entry");
      chk("nobrk_flag", brk_m, 0);
      clk_n(20);
      chk("nobrk_empty", rx_valid_m, 0);
`endif

      // reset in the middle of a frame forces the line high at once
      sel     = 2'd0;
      tx_data = 8'h00;
      tx_wr   = 1'b1;
      clk_n(1);
      tx_wr   = 1'b0;
      clk_n(30);
      chk("midframe_low", txd_m, 0);
      rst = 1'b1;
      #1;
      chk("midframe_rst_txd", txd_m, 1);
      chk("midframe_rst_idle", tx_idle_m, 1);
      clk_n(2);
      rst = 1'b0;
      clk_n(40);
      chk("post_rst_txd", txd_m, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/uart_xcvr_fifo.md
Name: uart_xcvr_fifo

Overview:
- Single-clock, parametrised UART transceiver for the Bluetooth/RS232 link.
- Contains:
  - a 16x oversampling baud tick generator;
  - a receiver with synchroniser, parity and framing check;
  - a transmitter;
  - a synchronous FIFO on each side.
- Successor to the fixed 8N1 dual-clock transceiver top: data width, parity, stop bits and both FIFO depths are configurable, and per-character error status is carried through the RX FIFO.
- Sits between the pin buffers and the AXI bridge logic.

Parameters:
- CLOCK_RATE, 100_000_000, clk_sys frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- DATA_BITS, 8, character width; legal range 5..8
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits transmitted (1 or 2); the receiver always checks only the first
- TX_FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2
- RX_FIFO_DEPTH, 16, RX FIFO entries; power of two, >= 2

Ports:
- clk_sys  in  1  system clock
- rst_clk_sys  in  1  reset, asynchronous assert, active-high
- rxd_i  in  1  serial receive line, asynchronous
- txd_o  out  1  serial transmit line
- tx_data  in  DATA_BITS  character to queue
- tx_wr_en  in  1  push tx_data into the TX FIFO
- tx_full  out  1  TX FIFO full
- tx_idle  out  1  TX FIFO empty and transmitter in IDLE
- rx_data  out  DATA_BITS  head of the RX FIFO (first-word fall-through)
- rx_valid  out  1  RX FIFO not empty
- rx_rd_en  in  1  pop the RX FIFO head
- rx_frm_err  out  1  head character had stop bit = 0
- rx_par_err  out  1  head character failed the parity check
- rx_overrun  out  1  sticky: a character was dropped because the RX FIFO was full
- rx_err_clr  in  1  clear rx_overrun and rx_break
- rx_break  out  1  sticky break-detected flag (see Optional Feature)

Behaviour:
- Reset values:
  - txd_o=1, tx_full=0, tx_idle=1.
  - rx_valid=0, rx_data=0, rx_frm_err=0, rx_par_err=0, rx_overrun=0, rx_break=0.
  - Both FIFOs empty; both FSMs in IDLE; tick counter 0.
  - Reset mid-frame aborts the frame; txd_o returns to 1 immediately (asynchronous).
- Tick generator:
  - DIV = (CLOCK_RATE + 8*BAUD_RATE) / (16*BAUD_RATE), integer, minimum 1.
  - Free-running counter emits a 1-cycle tick every DIV clocks; 16 ticks = 1 bit.
- RX synchroniser: 2 flops on rxd_i, reset to 1. Start detection uses the synchronised line only.
- RX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - IDLE: on a tick with the line low, go to START with the tick count cleared.
  - START: at tick count 7 the line is re-sampled; if high it is a glitch and the FSM returns to IDLE with nothing pushed.
  - DATA and later states: each bit is sampled every 16 ticks from the centre point, LSB first.
  - STOP: push {par_err, frm_err, data} into the RX FIFO, then go to IDLE.
  - Odd parity check: data XOR parity bit must equal 1. Even: must equal 0.
- RX FIFO:
  - Push when full: the character is dropped and rx_overrun sets.
  - rx_rd_en with rx_valid=0 is ignored.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Status outputs rx_frm_err and rx_par_err track the head entry and are valid while rx_valid=1.
- TX FIFO:
  - tx_wr_en while tx_full=1 is ignored, even if a pop happens in the same cycle.
  - Simultaneous push and pop are both performed.
- TX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty, pop on the next tick and drive the start bit.
  - Each bit is held for 16 ticks; data is sent LSB first.
  - Parity bit: odd mode sends ~^data, even mode sends ^data.
  - STOP lasts STOP_BITS*16 ticks; back-to-back characters follow with no idle gap.
- rx_err_clr: clears both sticky flags. If it coincides with a set event, the set wins.

Optional Feature:
- Macro: UART_BREAK_DET_EN.
- When defined: in STOP, if all data bits, the parity bit and the stop bit were 0, rx_break sets (sticky).
  - The 0x00 character is still pushed with frm_err=1.
  - The RX FSM then waits in a BREAK state until the line is high for 16 consecutive ticks before returning to IDLE.
- When undefined: rx_break is tied 0, there is no BREAK state, and the RX FSM returns to IDLE directly after STOP.

Test Plan:
All scenarios use CLOCK_RATE=1_600_000 and BAUD_RATE=100_000, giving DIV=1 and 16 clocks per bit.
- TX 8N1: push 0xA5 -> txd_o sequence 0,1,0,1,0,0,1,0,1,1, 16 clocks per bit; frame is 160 clocks; tx_idle returns to 1 afterwards.
- TX 8E2: push 0xA5 -> parity bit 0 followed by 32 clocks high. With PARITY=1 the parity bit is 1.
- RX loop: drive 0x3C, 0xFF, 0x00 serially as 8N1 -> rx_valid=1 and rx_data reads 0x3C, 0xFF, 0x00 in order via rx_rd_en, with both error flags 0.
- RX errors:
  - 0x55 with stop bit 0 -> head entry 0x55 with rx_frm_err=1.
  - 8O1 frame with a wrong parity bit -> rx_par_err=1.
  - A 6-clock low glitch -> no entry pushed.
- Overrun (RX_FIFO_DEPTH=4): receive 5 characters without reading -> the first 4 are retained, rx_overrun=1; after rx_err_clr, rx_overrun=0.
- Break (macro defined): hold rxd_i low for 320 clocks, then high -> entry 0x00 with frm_err=1, rx_break=1, and exactly one entry pushed.
